// File: rtl/ux607_sram_arb2.sv
// ============================================================================
// ux607_sram_arb2 : two-port round-robin arbiter/sequencer for one SRAM macro
// Revision 1.0
// ============================================================================
`default_nettype none

module ux607_sram_arb2 #(
  parameter int DP = 512,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_cmd_valid,
  output logic          p0_cmd_ready,
  input  logic          p0_cmd_read,
  input  logic [AW-1:0] p0_cmd_addr,
  input  logic [DW-1:0] p0_cmd_wdata,
  input  logic [MW-1:0] p0_cmd_wmask,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [DW-1:0] p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_cmd_valid,
  output logic          p1_cmd_ready,
  input  logic          p1_cmd_read,
  input  logic [AW-1:0] p1_cmd_addr,
  input  logic [DW-1:0] p1_cmd_wdata,
  input  logic [MW-1:0] p1_cmd_wmask,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] DP_LIM = (AW+1)'(DP);

  logic          rr_r;
  logic          pend_r, pend_port_r, pend_rd_r, pend_err_r;
  logic          hold_vld_r, hold_port_r, hold_err_r;
  logic [DW-1:0] hold_data_r;
  logic [AW-1:0] addr_last_r;
  logic [DW-1:0] din_last_r;

  logic          pend_rsp_ready, issue_ok, accept, sel, grant0, grant1;
  logic          sel_read, in_range;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmask;
  logic [DW-1:0] pend_data, cur_data;
  logic          cur_valid, cur_port, cur_err, cur_ready;

  // Arbitration: a lone requester always wins; rr_r breaks ties.
  assign grant1 = p1_cmd_valid & (~p0_cmd_valid | rr_r);
  assign grant0 = p0_cmd_valid & (~p1_cmd_valid | ~rr_r);
  assign sel    = grant1;

  assign pend_rsp_ready = pend_port_r ? p1_rsp_ready : p0_rsp_ready;
  assign issue_ok       = rst_n & ~hold_vld_r & (~pend_r | pend_rsp_ready);
  assign accept         = issue_ok & (p0_cmd_valid | p1_cmd_valid);

  assign p0_cmd_ready = issue_ok & grant0;
  assign p1_cmd_ready = issue_ok & grant1;

  assign sel_read  = sel ? p1_cmd_read  : p0_cmd_read;
  assign sel_addr  = sel ? p1_cmd_addr  : p0_cmd_addr;
  assign sel_wdata = sel ? p1_cmd_wdata : p0_cmd_wdata;
  assign sel_wmask = sel ? p1_cmd_wmask : p0_cmd_wmask;
  assign in_range  = ({1'b0, sel_addr} < DP_LIM);

  assign ram_cs   = accept & in_range;
  assign ram_wem  = (ram_cs & ~sel_read) ? sel_wmask : '0;
  assign ram_addr = accept ? sel_addr  : addr_last_r;
  assign ram_din  = accept ? sel_wdata : din_last_r;

  // hold_vld_r and pend_r are never set together: nothing issues while holding.
  assign pend_data = (pend_r & pend_rd_r & ~pend_err_r) ? ram_dout : '0;
  assign cur_valid = hold_vld_r | pend_r;
  assign cur_port  = hold_vld_r ? hold_port_r : pend_port_r;
  assign cur_data  = hold_vld_r ? hold_data_r : pend_data;
  assign cur_err   = hold_vld_r ? hold_err_r  : (pend_r & pend_err_r);
  assign cur_ready = cur_port ? p1_rsp_ready : p0_rsp_ready;

  assign p0_rsp_valid = cur_valid & ~cur_port;
  assign p1_rsp_valid = cur_valid & cur_port;
  assign p0_rsp_rdata = p0_rsp_valid ? cur_data : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? cur_data : '0;
  assign p0_rsp_err   = p0_rsp_valid & cur_err;
  assign p1_rsp_err   = p1_rsp_valid & cur_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r        <= 1'b0;
      pend_r      <= 1'b0;
      pend_port_r <= 1'b0;
      pend_rd_r   <= 1'b0;
      pend_err_r  <= 1'b0;
      hold_vld_r  <= 1'b0;
      hold_port_r <= 1'b0;
      hold_err_r  <= 1'b0;
      hold_data_r <= '0;
      addr_last_r <= '0;
      din_last_r  <= '0;
    end else begin
      pend_r <= accept;
      if (accept) begin
        rr_r        <= ~sel;
        pend_port_r <= sel;
        pend_rd_r   <= sel_read;
        pend_err_r  <= ~in_range;
        addr_last_r <= sel_addr;
        din_last_r  <= sel_wdata;
      end
      if (hold_vld_r) begin
        if (cur_ready) hold_vld_r <= 1'b0;
      end else if (pend_r & ~pend_rsp_ready) begin
        hold_vld_r  <= 1'b1;
        hold_port_r <= pend_port_r;
        hold_data_r <= pend_data;
        hold_err_r  <= pend_err_r;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ux607_sram_arb2.sv
// ============================================================================
// tb_ux607_sram_arb2 : directed scenarios plus randomized transaction-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ux607_sram_arb2;
  localparam int DP = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_cmd_valid, p0_cmd_ready, p0_cmd_read, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic [31:0] p0_cmd_addr, p0_cmd_wdata, p0_rsp_rdata;
  logic [3:0]  p0_cmd_wmask;
  logic        p1_cmd_valid, p1_cmd_ready, p1_cmd_read, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [31:0] p1_cmd_addr, p1_cmd_wdata, p1_rsp_rdata;
  logic [3:0]  p1_cmd_wmask;
  logic        ram_cs;
  logic [31:0] ram_addr, ram_din;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout = '0;

  logic [31:0] ram  [DP];
  logic [31:0] gmem [DP];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ux607_sram_arb2 #(.DP(DP), .DW(32), .MW(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(p0_cmd_ready), .p0_cmd_read(p0_cmd_read),
    .p0_cmd_addr(p0_cmd_addr), .p0_cmd_wdata(p0_cmd_wdata), .p0_cmd_wmask(p0_cmd_wmask),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(p1_cmd_ready), .p1_cmd_read(p1_cmd_read),
    .p1_cmd_addr(p1_cmd_addr), .p1_cmd_wdata(p1_cmd_wdata), .p1_cmd_wmask(p1_cmd_wmask),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wem(ram_wem),
    .ram_dout(ram_dout)
  );

  // Single-port SRAM with byte write enables and one-cycle registered read
  always @(posedge clk) begin
    if (ram_cs) begin
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) ram[ram_addr[8:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
      ram_dout <= ram[ram_addr[8:0]];
    end
  end

  task automatic idle();
    p0_cmd_valid = 0; p0_cmd_read = 0; p0_cmd_addr = '0; p0_cmd_wdata = '0; p0_cmd_wmask = '0;
    p1_cmd_valid = 0; p1_cmd_read = 0; p1_cmd_addr = '0; p1_cmd_wdata = '0; p1_cmd_wmask = '0;
    p0_rsp_ready = 1; p1_rsp_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    p0_cmd_valid = 1; p1_cmd_valid = 1;
    #1;
    vectors++; if (p0_cmd_ready !== 1'b0 || p1_cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready got %b%b exp 00", p0_cmd_ready, p1_cmd_ready); end
    vectors++; if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b%b exp 00", p0_rsp_valid, p1_rsp_valid); end
    vectors++; if (ram_cs !== 1'b0 || ram_wem !== 4'h0) begin miscompares++; $display("FAIL rst_ram_ctl got cs %b wem %h exp 0 0", ram_cs, ram_wem); end
    vectors++; if (ram_addr !== 32'h0 || ram_din !== 32'h0) begin miscompares++; $display("FAIL rst_ram_bus got %h %h exp 0 0", ram_addr, ram_din); end
    vectors++; if (p0_rsp_rdata !== 32'h0 || p0_rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp got %h %b exp 0 0", p0_rsp_rdata, p0_rsp_err); end
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    idle();
    p0_cmd_valid = 1; p0_cmd_read = 0; p0_cmd_addr = 5; p0_cmd_wdata = 32'hDEADBEEF; p0_cmd_wmask = 4'hF;
    #1;
    vectors++; if (p0_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready got %b exp 1", p0_cmd_ready); end
    vectors++; if (ram_cs !== 1'b1 || ram_wem !== 4'hF || ram_addr !== 32'd5 || ram_din !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL wr_ram got cs %b wem %h addr %h din %h exp 1 f 5 deadbeef", ram_cs, ram_wem, ram_addr, ram_din); end
    @(posedge clk);
    gmem[5] = 32'hDEADBEEF;
    @(negedge clk);
    p0_cmd_read = 1; p0_cmd_wdata = 32'h0; p0_cmd_wmask = 4'hF;
    #1;
    vectors++; if (p0_cmd_ready !== 1'b1 || ram_cs !== 1'b1 || ram_wem !== 4'h0) begin
      miscompares++; $display("FAIL rd_issue got ready %b cs %b wem %h exp 1 1 0", p0_cmd_ready, ram_cs, ram_wem); end
    vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h0 || p0_rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL wr_rsp got v %b d %h e %b exp 1 0 0", p0_rsp_valid, p0_rsp_rdata, p0_rsp_err); end
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL rd_rsp got v %b d %h exp 1 deadbeef", p0_rsp_valid, p0_rsp_rdata); end
    @(posedge clk);
  endtask

  task automatic test_byte_mask();
    logic [31:0] wd [2];
    logic [3:0]  wm [2];
    wd[0] = 32'h11223344; wm[0] = 4'hF;
    wd[1] = 32'hAABBCCDD; wm[1] = 4'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      p0_cmd_valid = 1; p0_cmd_addr = 6;
      p0_cmd_read  = (i == 2);
      if (i < 2) begin p0_cmd_wdata = wd[i]; p0_cmd_wmask = wm[i]; end
      #1;
      vectors++; if (p0_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mask_ready%0d got %b exp 1", i, p0_cmd_ready); end
      @(posedge clk);
    end
    gmem[6] = 32'h11BB33DD;
    @(negedge clk);
    idle();
    #1;
    vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h11BB33DD) begin
      miscompares++; $display("FAIL mask_rd got v %b d %h exp 1 11bb33dd", p0_rsp_valid, p0_rsp_rdata); end
    @(posedge clk);
  endtask

  task automatic test_alternate();
    int k0 = 0, k1 = 0, ep;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      idle();
      p0_cmd_valid = (k0 < 8); p0_cmd_read = 1; p0_cmd_addr = 32'(10 + k0);
      p1_cmd_valid = (k1 < 8); p1_cmd_read = 1; p1_cmd_addr = 32'(100 + k1);
      #1;
      if (i < 16) begin
        ep = i % 2;
        vectors++; if (p0_cmd_ready !== (ep == 0) || p1_cmd_ready !== (ep == 1)) begin
          miscompares++; $display("FAIL alt_grant cyc %0d got %b%b exp port %0d", i, p0_cmd_ready, p1_cmd_ready, ep); end
        vectors++; if (ram_cs !== 1'b1 || ram_addr !== 32'(ep ? 100 + k1 : 10 + k0)) begin
          miscompares++; $display("FAIL alt_ram cyc %0d got cs %b addr %0d", i, ram_cs, ram_addr); end
        if (ep == 0) k0++; else k1++;
      end
      if (i > 0) begin
        ep = (i - 1) % 2;
        vectors++;
        if (ep == 0 ? (p0_rsp_valid !== 1'b1 || p1_rsp_valid !== 1'b0 || p0_rsp_rdata !== gmem[10 + (i-1)/2])
                    : (p1_rsp_valid !== 1'b1 || p0_rsp_valid !== 1'b0 || p1_rsp_rdata !== gmem[100 + (i-1)/2])) begin
          miscompares++; $display("FAIL alt_rsp cyc %0d got v %b%b d %h %h exp port %0d", i, p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata, ep); end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    idle();
    p1_cmd_valid = 1; p1_cmd_read = 1; p1_cmd_addr = 100;
    #1;
    vectors++; if (p1_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_issue got %b exp 1", p1_cmd_ready); end
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      idle();
      p0_cmd_valid = 1; p0_cmd_read = 0; p0_cmd_addr = 7; p0_cmd_wdata = 32'hCAFEF00D; p0_cmd_wmask = 4'hF;
      p1_rsp_ready = (c == 4);
      #1;
      vectors++; if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== gmem[100] || p1_rsp_err !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold cyc %0d got v %b d %h exp 1 %h", c, p1_rsp_valid, p1_rsp_rdata, gmem[100]); end
      vectors++; if (p0_cmd_ready !== 1'b0 || ram_cs !== 1'b0) begin
        miscompares++; $display("FAIL bp_block cyc %0d got ready %b cs %b exp 0 0", c, p0_cmd_ready, ram_cs); end
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    vectors++; if (p1_rsp_valid !== 1'b0 || p0_cmd_ready !== 1'b1 || ram_cs !== 1'b1) begin
      miscompares++; $display("FAIL bp_resume got v1 %b ready0 %b cs %b exp 0 1 1", p1_rsp_valid, p0_cmd_ready, ram_cs); end
    @(posedge clk);
    gmem[7] = 32'hCAFEF00D;
    @(negedge clk);
    idle();
    #1;
    vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL bp_wrsp got v %b d %h exp 1 0", p0_rsp_valid, p0_rsp_rdata); end
    @(posedge clk);
  endtask

  task automatic test_error();
    @(negedge clk);
    idle();
    p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = DP;
    #1;
    vectors++; if (p0_cmd_ready !== 1'b1 || ram_cs !== 1'b0 || ram_wem !== 4'h0) begin
      miscompares++; $display("FAIL err_rd got ready %b cs %b wem %h exp 1 0 0", p0_cmd_ready, ram_cs, ram_wem); end
    @(posedge clk);
    @(negedge clk);
    idle();
    p1_cmd_valid = 1; p1_cmd_read = 0; p1_cmd_addr = DP + 7; p1_cmd_wdata = 32'hFFFFFFFF; p1_cmd_wmask = 4'hF;
    #1;
    vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_err !== 1'b1 || p0_rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL err_rd_rsp got v %b e %b d %h exp 1 1 0", p0_rsp_valid, p0_rsp_err, p0_rsp_rdata); end
    vectors++; if (p1_cmd_ready !== 1'b1 || ram_cs !== 1'b0 || ram_wem !== 4'h0) begin
      miscompares++; $display("FAIL err_wr got ready %b cs %b wem %h exp 1 0 0", p1_cmd_ready, ram_cs, ram_wem); end
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    vectors++; if (p1_rsp_valid !== 1'b1 || p1_rsp_err !== 1'b1 || p1_rsp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL err_wr_rsp got v %b e %b d %h exp 1 1 0", p1_rsp_valid, p1_rsp_err, p1_rsp_rdata); end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    p0_cmd_valid = 1; p0_cmd_read = 1; p0_cmd_addr = 10; p0_rsp_ready = 0;
    @(posedge clk);
    @(negedge clk);
    p0_cmd_valid = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== gmem[10]) begin
      miscompares++; $display("FAIL rm_hold got v %b d %h exp 1 %h", p0_rsp_valid, p0_rsp_rdata, gmem[10]); end
    #1;
    rst_n = 0;
    p0_cmd_valid = 1; p1_cmd_valid = 1; p1_cmd_read = 1; p1_cmd_addr = 11;
    #1;
    vectors++; if (p0_rsp_valid !== 1'b0 || p0_cmd_ready !== 1'b0 || p1_cmd_ready !== 1'b0 || ram_cs !== 1'b0) begin
      miscompares++; $display("FAIL rm_drop got v %b rdy %b%b cs %b exp 0 00 0", p0_rsp_valid, p0_cmd_ready, p1_cmd_ready, ram_cs); end
    @(negedge clk);
    rst_n = 1; p0_rsp_ready = 1;
    #1;
    vectors++; if (p0_cmd_ready !== 1'b1 || p1_cmd_ready !== 1'b0 || ram_addr !== 32'd10) begin
      miscompares++; $display("FAIL rm_first got rdy %b%b addr %0d exp 10 10", p0_cmd_ready, p1_cmd_ready, ram_addr); end
    @(posedge clk);
    @(negedge clk);
    idle();
    @(posedge clk);
  endtask

  // Transaction-level model: one response slot, fresh on its first cycle
  task automatic test_random();
    bit          out_v = 0, out_fresh = 0, out_err = 0;
    int          out_port = 0, fav = 0, win;
    logic [31:0] out_data = '0;
    bit          v[2], rd[2], rr[2], can_issue, inr, exp_cs;
    logic [31:0] a[2], wd[2];
    logic [3:0]  wm[2];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        v[p]  = ($urandom_range(0, 3) != 0);
        rd[p] = $urandom_range(0, 1) == 1;
        a[p]  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(505, 520)) : 32'($urandom_range(0, 15));
        wd[p] = $urandom;
        wm[p] = 4'($urandom_range(0, 15));
        rr[p] = ($urandom_range(0, 3) != 0);
      end
      p0_cmd_valid = v[0]; p0_cmd_read = rd[0]; p0_cmd_addr = a[0]; p0_cmd_wdata = wd[0]; p0_cmd_wmask = wm[0]; p0_rsp_ready = rr[0];
      p1_cmd_valid = v[1]; p1_cmd_read = rd[1]; p1_cmd_addr = a[1]; p1_cmd_wdata = wd[1]; p1_cmd_wmask = wm[1]; p1_rsp_ready = rr[1];
      #1;
      can_issue = !out_v || (out_fresh && rr[out_port]);
      win = (v[0] && v[1]) ? fav : (v[0] ? 0 : (v[1] ? 1 : -1));
      if (!can_issue) win = -1;
      inr = (win >= 0) && (a[win] < DP);
      exp_cs = inr;
      vectors++; if (p0_cmd_ready !== (win == 0) || p1_cmd_ready !== (win == 1)) begin
        miscompares++; $display("FAIL rnd_ready cyc %0d got %b%b exp win %0d", cyc, p0_cmd_ready, p1_cmd_ready, win); end
      vectors++; if (p0_rsp_valid !== (out_v && out_port == 0) || p1_rsp_valid !== (out_v && out_port == 1)) begin
        miscompares++; $display("FAIL rnd_rsp_valid cyc %0d got %b%b exp v %b port %0d", cyc, p0_rsp_valid, p1_rsp_valid, out_v, out_port); end
      if (out_v) begin
        vectors++;
        if ((out_port == 0 ? p0_rsp_rdata : p1_rsp_rdata) !== out_data || (out_port == 0 ? p0_rsp_err : p1_rsp_err) !== out_err) begin
          miscompares++; $display("FAIL rnd_rsp_data cyc %0d got %h/%b %h/%b exp %h/%b on port %0d", cyc, p0_rsp_rdata, p0_rsp_err, p1_rsp_rdata, p1_rsp_err, out_data, out_err, out_port); end
      end
      vectors++; if (ram_cs !== exp_cs) begin miscompares++; $display("FAIL rnd_cs cyc %0d got %b exp %b", cyc, ram_cs, exp_cs); end
      vectors++;
      if (exp_cs ? (ram_addr !== a[win] || ram_wem !== (rd[win] ? 4'h0 : wm[win]) || (!rd[win] && ram_din !== wd[win]))
                 : (ram_wem !== 4'h0)) begin
        miscompares++; $display("FAIL rnd_ram cyc %0d got addr %0d wem %h din %h", cyc, ram_addr, ram_wem, ram_din); end
      if (out_v && rr[out_port]) out_v = 0;
      else if (out_v) out_fresh = 0;
      if (win >= 0) begin
        out_v = 1; out_fresh = 1; out_port = win; out_err = !inr;
        out_data = (inr && rd[win]) ? gmem[a[win]] : 32'h0;
        if (inr && !rd[win])
          for (int b = 0; b < 4; b++) if (wm[win][b]) gmem[a[win]][b*8 +: 8] = wd[win][b*8 +: 8];
        fav = 1 - win;
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic test_memory();
    int bad = 0;
    for (int i = 0; i < DP; i++) if (ram[i] !== gmem[i]) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL mem_contents got %0d differing words exp 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < DP; i++) begin
      ram[i]  = 32'(i) * 32'h01010101 ^ 32'hA5A5A5A5;
      gmem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A5A5A5;
    end
    test_reset();
    test_write_read();
    test_byte_mask();
    test_alternate();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_random();
    test_memory();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ux607_sram_arb2.md
# ux607_sram_arb2

Two-requester arbiter and sequencer for one single-port synchronous SRAM macro (byte-write-enable, 1-cycle read latency, output registered on address). It sits between two master ports (port 0: core-side, port 1: DMA/debug-side) and the RAM's clk/din/addr/cs/wem/dout pins. It grants the RAM round-robin, issues at most one access per cycle and returns an in-order response to the issuing port. A one-entry hold buffer absorbs response back-pressure. Out-of-range addresses get an error response and no RAM access.

## Interface
- DP, 512: RAM depth in words; legal index range is 0..DP-1
- DW, 32: data width
- MW, 4: byte-mask width, MW*8 >= DW
- AW, 32: address (word index) width
- clk  in  1  clock shared with the RAM
- rst_n  in  1  asynchronous active-low reset
- pN_cmd_valid  in  1  command request, N = 0, 1
- pN_cmd_ready  out  1  command accepted when valid & ready
- pN_cmd_read  in  1  1 = read, 0 = write
- pN_cmd_addr  in  AW  word index
- pN_cmd_wdata  in  DW  write data
- pN_cmd_wmask  in  MW  byte write enables; ignored for reads
- pN_rsp_valid  out  1  response valid
- pN_rsp_ready  in  1  response accepted when valid & ready
- pN_rsp_rdata  out  DW  read data; 0 for writes and errors
- pN_rsp_err  out  1  address >= DP
- ram_cs  out  1  RAM chip select
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_wem  out  MW  RAM byte write mask
- ram_dout  in  DW  RAM read data, valid the cycle after cs

## Operation
- State registers:
  - rr_r: priority pointer, reset 0 (port 0 favoured)
  - pend_r, pend_port_r, pend_rd_r, pend_err_r: access issued last cycle
  - hold_vld_r, hold_port_r, hold_data_r, hold_err_r: buffered response
- issue_ok = !hold_vld_r & (!pend_r | pN_rsp_ready for N = pend_port_r).
- Grant: if only one port is valid, that port wins. If both are valid, port rr_r wins. On every accepted command, rr_r <= ~granted port. rr_r is unchanged when no command is accepted.
- pN_cmd_ready = issue_ok & grant_N. This is combinational from valid/rsp_ready and must not depend on its own cmd_valid beyond the arbitration.
- Accept with addr < DP:
  - ram_cs = 1, ram_addr = cmd_addr, ram_din = cmd_wdata
  - ram_wem = read ? 0 : cmd_wmask
- Accept with addr >= DP: ram_cs = 0, ram_wem = 0. A pending entry is recorded with err = 1.
- When no command is accepted: ram_cs = 0, ram_wem = 0, and ram_addr/ram_din hold their last value.
- Pending response, when pend_r = 1:
  - The port pend_port_r sees rsp_valid = 1
  - rdata = (pend_rd_r & !pend_err_r) ? ram_dout[DW-1:0] : 0
  - rsp_err = pend_err_r
- If that port's rsp_ready = 0, the response moves into the hold buffer next cycle: hold_vld_r <= 1, with its data, error and port.
- While hold_vld_r = 1, the response is driven from the hold buffer. It clears when rsp_ready = 1. No command is accepted while hold_vld_r = 1.
- The non-target port always has rsp_valid = 0.
- Ordering: responses are strictly in issue order, and at most one response is outstanding.
- Reset (async, mid-operation included) clears all state: rr_r = 0, pend_r = 0, hold_vld_r = 0. Any in-flight response is discarded. Outputs after reset:
  - All cmd_ready and rsp_valid = 0 until rst_n deasserts
  - ram_cs = 0, ram_wem = 0
  - ram_addr = 0, ram_din = 0, rdata = 0, err = 0

## Timing
- Command accepted in cycle T → response valid in T+1 (zero-wait) or later (held).
- Throughput: 1 access/cycle when responses are accepted the cycle they appear. A new command may be accepted in the same cycle a response is accepted.
- Back-pressure: rsp_ready low in T+1 → response re-presented from the hold buffer in T+2 onward, unchanged. The next command is accepted no earlier than the cycle after hold_vld_r clears.
- Both ports valid every cycle with rsp_ready = 1 → grants alternate 0,1,0,1...
- Error responses use the same latency and back-pressure rules as RAM accesses.
- Read-after-write to the same address on consecutive cycles returns the new data. The write is committed at the T edge; the read is issued at T+1.

## Test plan
- Reset then p0 write addr 5 = 0xDEADBEEF, mask 0xF; p0 read addr 5 → cmd_ready both cycles; responses in T+1 with rdata 0 (write) then 0xDEADBEEF.
- Byte mask: write 0x11223344 mask 0xF, then 0xAABBCCDD mask 0x5, read → 0x11BB33DD.
- Both ports continuously valid, rsp_ready = 1, 8 commands each → alternating grants starting with port 0, ram_cs high every cycle, all 16 responses routed correctly.
- p1 read with p1_rsp_ready low for 3 cycles while p0 is valid → p1 rsp_valid held with constant data, p0_cmd_ready = 0 throughout, p0 accepted in the cycle after p1's response handshakes.
- Read addr DP and write addr DP+7 → ram_cs = 0, rsp_err = 1, rdata = 0; memory contents unchanged.
- Assert rst_n low while hold_vld_r = 1 → rsp_valid, cmd_ready and ram_cs drop immediately; after release, port 0 wins the first contention.
